// File: rtl/layer_train_driver_pkg.sv
// Shared types for the layer training driver: the zero2one_t sample element
// and the sequencer state encoding.
package layer_train_driver_pkg;

  localparam int unsigned ZW = 8;

  typedef logic [ZW-1:0] zero2one_t;

  localparam zero2one_t ZERO2ONE_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_LEARN,
    ST_SCORE,
    ST_RESULT
  } state_t;

  function automatic zero2one_t z2o_absdiff(input zero2one_t a, input zero2one_t b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/layer_train_driver_argmax_scan.sv
// Sequential argmax over M zero2one_t elements, one element per step.
// Strict greater-than keeps the lowest index on ties. Exposes the scan index
// when LAYER_TRAIN_LOSS_EN is defined.
module argmax_scan
  import layer_train_driver_pkg::*;
#(
  parameter  int M  = 29,
  localparam int IW = (M > 1) ? $clog2(M) : 1
)(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic              i_step,
  input  zero2one_t [M-1:0] i_data,
`ifdef LAYER_TRAIN_LOSS_EN
  output logic [IW-1:0]     o_idx,
`endif
  output logic              o_done,
  output logic [IW-1:0]     o_best_idx
);

  localparam logic [IW-1:0] LAST = IW'(M - 1);

  logic [IW-1:0] r_idx;
  zero2one_t     r_best_val;
  zero2one_t     w_cur;

  assign w_cur = i_data[r_idx];

`ifdef LAYER_TRAIN_LOSS_EN
  assign o_idx = r_idx;
`endif

  // A zero initial best lets element 0 win when every element is zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_idx      <= '0;
      r_best_val <= '0;
      o_best_idx <= '0;
      o_done     <= 1'b0;
    end else if (i_start) begin
      r_idx      <= '0;
      r_best_val <= '0;
      o_best_idx <= '0;
      o_done     <= 1'b0;
    end else if (i_step && !o_done) begin
      if (w_cur > r_best_val) begin
        r_best_val <= w_cur;
        o_best_idx <= r_idx;
      end
      if (r_idx == LAST) begin
        o_done <= 1'b1;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/layer_train_driver.sv
// Sequencer in front of a neuron learning layer: accepts a labelled sample,
// drives the layer, scores its outputs by argmax and reports the result.
// Optional loss accumulator output enabled by LAYER_TRAIN_LOSS_EN.
module layer_train_driver
  import layer_train_driver_pkg::*;
#(
  parameter int N      = 16,
  parameter int M      = 29,
  parameter int SETTLE = 2,
  parameter int CW     = 16,
  parameter int LW     = $clog2(M)
)(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  zero2one_t [N-1:0] s_in,
  input  logic [LW-1:0]     s_label,
  input  logic              s_train,
  output zero2one_t [N-1:0] l_in,
  output logic              l_valid,
  output logic              l_learn,
  output zero2one_t [M-1:0] l_expected_out,
  input  zero2one_t [M-1:0] l_out,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [LW-1:0]     r_pred,
  output logic              r_correct,
  input  logic              cnt_clear,
  output logic [CW-1:0]     sample_cnt,
  output logic [CW-1:0]     correct_cnt
`ifdef LAYER_TRAIN_LOSS_EN
  ,
  output logic [31:0]       loss_acc
`endif
);

  localparam int            SW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [LW:0]   M_LIM = (LW + 1)'(M);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SW-1:0]     r_settle;
  logic [LW-1:0]     r_label;
  logic              r_train;

  logic              w_accept;
  logic              w_start;
  logic              w_step;
  logic              w_take;
  logic              w_done;
  logic              w_label_ok;
  logic [LW-1:0]     w_best_idx;
  zero2one_t [M-1:0] w_onehot;

`ifdef LAYER_TRAIN_LOSS_EN
  logic [LW-1:0]     w_scan_idx;
`endif

  argmax_scan #(.M(M)) u_scan (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_start    (w_start),
    .i_step     (w_step),
    .i_data     (l_out),
`ifdef LAYER_TRAIN_LOSS_EN
    .o_idx      (w_scan_idx),
`endif
    .o_done     (w_done),
    .o_best_idx (w_best_idx)
  );

  always_comb begin
    w_onehot = '0;
    for (int unsigned i = 0; i < M; i++) begin
      if (s_label == LW'(i)) w_onehot[i] = ZERO2ONE_MAX;
    end
  end

  assign w_label_ok = ({1'b0, r_label} < M_LIM);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_start     = 1'b0;
    w_step      = 1'b0;
    w_take      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (s_valid && s_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (r_settle == '0) begin
          w_state_nxt = r_train ? ST_LEARN : ST_SCORE;
          w_start     = !r_train;
        end
      end
      ST_LEARN: begin
        w_state_nxt = ST_SCORE;
        w_start     = 1'b1;
      end
      ST_SCORE: begin
        if (w_done) w_state_nxt = ST_RESULT;
        else        w_step      = 1'b1;
      end
      ST_RESULT: begin
        if (r_ready) begin
          w_take      = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake and layer strobes are registered from the next state so they
  // line up with the state they describe and clear asynchronously on reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s_ready        <= 1'b0;
      l_valid        <= 1'b0;
      l_learn        <= 1'b0;
      l_in           <= '0;
      l_expected_out <= '0;
      r_valid        <= 1'b0;
      r_pred         <= '0;
      r_correct      <= 1'b0;
      r_label        <= '0;
      r_train        <= 1'b0;
      r_settle       <= '0;
    end else begin
      s_ready <= (w_state_nxt == ST_IDLE);
      l_valid <= (w_state_nxt inside {ST_SETTLE, ST_LEARN, ST_SCORE});
      l_learn <= (w_state_nxt == ST_LEARN);

      if (w_accept) begin
        l_in           <= s_in;
        r_label        <= s_label;
        r_train        <= s_train;
        l_expected_out <= w_onehot;
        r_settle       <= SW'(SETTLE - 1);
      end else if ((r_state == ST_SETTLE) && (r_settle != '0)) begin
        r_settle <= r_settle - 1'b1;
      end

      if ((r_state == ST_SCORE) && w_done) begin
        r_valid   <= 1'b1;
        r_pred    <= w_best_idx;
        r_correct <= (w_best_idx == r_label) && w_label_ok;
      end

      if (w_take) begin
        r_valid        <= 1'b0;
        l_expected_out <= '0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sample_cnt  <= '0;
      correct_cnt <= '0;
    end else if (cnt_clear) begin
      sample_cnt  <= '0;
      correct_cnt <= '0;
    end else if (w_take) begin
      if (sample_cnt != '1) sample_cnt <= sample_cnt + CW'(1);
      if (r_correct && (correct_cnt != '1)) correct_cnt <= correct_cnt + CW'(1);
    end
  end

`ifdef LAYER_TRAIN_LOSS_EN
  zero2one_t   w_loss_term;
  logic [32:0] w_loss_sum;

  assign w_loss_term = z2o_absdiff(l_out[w_scan_idx], l_expected_out[w_scan_idx]);
  assign w_loss_sum  = {1'b0, loss_acc} + 33'(w_loss_term);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      loss_acc <= '0;
    end else if (cnt_clear) begin
      loss_acc <= '0;
    end else if (w_step) begin
      loss_acc <= w_loss_sum[32] ? '1 : w_loss_sum[31:0];
    end
  end
`endif

endmodule
